even_updown_checker: RTL and testbench

- Receive-side monitor for the 4-bit even up-down counter.
- Samples the counter state bus and its direction input every clock and predicts the next even state.
- Acquires lock on the sequence, then flags illegal transitions and odd values, and keeps a saturating error count.
- Sits beside the counter in system and bench builds as the consumer and checker of its state stream.

---
 rtl/even_updown_checker.sv | 156 +++++++++++++++
 tb/tb_even_updown_checker.sv | 222 ++++++++++++++++++++++
 2 files changed

// File: rtl/even_updown_checker.sv
// ---------------------------------------------------------------------------
// even_updown_checker
//
// Receive-side monitor for a 4-bit even up/down counter. Every clock it
// samples the counter state and direction. From the previous state and the
// direction captured with it, it predicts the next even state. It acquires
// lock on the sequence, flags illegal transitions and odd values, and keeps
// a saturating error count.
//
// Optional build macro: EVEN_CHK_HOLD_EN
//   When this macro is defined, a repeated even sample (q_in == previous
//   sample) is a legal hold, as when the counter is clock-gated. A hold
//   changes nothing except the stored direction.
//   When the macro is not defined, a repeated value is an ordinary mismatch.
//
// Parameters:
//   WIDTH    - width of the observed counter state
//   LOCK_CNT - consecutive correct steps required for lock (1..15)
//   ERR_W    - width of the saturating error counter
//
// Ports:
//   clk       in   rising-edge clock, shared with the counter
//   reset     in   synchronous active-high reset
//   q_in      in   observed counter state, MSB first
//   y_in      in   observed direction (0 = up by 2, 1 = down by 2)
//   lock      out  sequence tracked and consistent
//   err_pulse out  one-cycle flag for an illegal sample
//   odd_err   out  one-cycle flag for a sample with q_in[0] = 1
//   dir_obs   out  direction of the last validated step
//   err_count out  saturating count of err_pulse events
// ---------------------------------------------------------------------------
module even_updown_checker #(
    parameter int WIDTH    = 4,
    parameter int LOCK_CNT = 2,
    parameter int ERR_W    = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] q_in,
    input  logic             y_in,
    output logic             lock,
    output logic             err_pulse,
    output logic             odd_err,
    output logic             dir_obs,
    output logic [ERR_W-1:0] err_count
);

    typedef enum logic [1:0] {
        SYNC   = 2'd0,
        ACQ    = 2'd1,
        LOCKED = 2'd2
    } state_t;

    state_t           r_state;
    logic [3:0]       r_match_cnt;
    logic [WIDTH-1:0] r_prev_q;
    logic             r_prev_y;

    logic [WIDTH-1:0] w_exp;
    logic             w_odd;
    logic             w_match;
    logic             w_hold;
    logic             w_err;
    logic [3:0]       w_cnt_nxt;

    // The prediction uses the direction captured together with the previous
    // state. Because of this, y_in can change on any edge without causing a
    // false error.
    assign w_exp     = r_prev_y ? (r_prev_q - WIDTH'(2)) : (r_prev_q + WIDTH'(2));
    assign w_odd     = q_in[0];
    assign w_match   = (q_in == w_exp) && !w_odd;
    assign w_cnt_nxt = r_match_cnt + 4'd1;

`ifdef EVEN_CHK_HOLD_EN
    // A paused counter repeats its value. An odd value can never be a hold.
    assign w_hold = (q_in == r_prev_q) && !w_odd;
`else
    assign w_hold = 1'b0;
`endif

    // In ACQ, only odd samples are reported as errors. In LOCKED, every
    // mismatch is reported. An odd sample is never a match or a hold.
    assign w_err = ((r_state == LOCKED) && !w_match && !w_hold) ||
                   ((r_state == ACQ) && w_odd);

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state     <= SYNC;
            r_match_cnt <= '0;
            r_prev_q    <= '0;
            r_prev_y    <= 1'b0;
            lock        <= 1'b0;
            err_pulse   <= 1'b0;
            odd_err     <= 1'b0;
            dir_obs     <= 1'b0;
            err_count   <= '0;
        end else begin
            r_prev_q  <= q_in;
            r_prev_y  <= y_in;
            err_pulse <= 1'b0;
            odd_err   <= 1'b0;

            case (r_state)
                SYNC: begin
                    // The first sample only becomes the reference. An odd
                    // value is still reported, but it does not count as an error.
                    odd_err <= w_odd;
                    r_state <= ACQ;
                end
                ACQ: begin
                    if (w_hold) begin
                        // Hold: leave the match count, lock and dir_obs unchanged.
                    end else if (w_match) begin
                        dir_obs <= r_prev_y;
                        if (w_cnt_nxt == 4'(LOCK_CNT)) begin
                            r_state     <= LOCKED;
                            lock        <= 1'b1;
                            r_match_cnt <= '0;
                        end else begin
                            r_match_cnt <= w_cnt_nxt;
                        end
                    end else begin
                        r_match_cnt <= '0;
                        odd_err     <= w_odd;
                        err_pulse   <= w_odd;
                    end
                end
                LOCKED: begin
                    if (w_hold) begin
                        // Hold: keep the lock.
                    end else if (w_match) begin
                        dir_obs <= r_prev_y;
                    end else begin
                        // The offending sample is already stored in r_prev_q.
                        // It becomes the reference for relocking.
                        err_pulse   <= 1'b1;
                        odd_err     <= w_odd;
                        lock        <= 1'b0;
                        r_state     <= ACQ;
                        r_match_cnt <= '0;
                    end
                end
                default: begin
                    r_state     <= SYNC;
                    r_match_cnt <= '0;
                    lock        <= 1'b0;
                end
            endcase

            // The error counter saturates at all-ones and does not wrap.
            if (w_err && (err_count != {ERR_W{1'b1}}))
                err_count <= err_count + ERR_W'(1);
        end
    end

endmodule

// File: tb/tb_even_updown_checker.sv
module tb_even_updown_checker;
    localparam int WIDTH    = 4;
    localparam int LOCK_CNT = 2;
    localparam int ERR_W    = 8;

`ifdef EVEN_CHK_HOLD_EN
    localparam bit HOLD_EN = 1'b1;
`else
    localparam bit HOLD_EN = 1'b0;
`endif

    logic             clk = 1'b0;
    logic             reset;
    logic [WIDTH-1:0] q_in;
    logic             y_in;
    logic             lock, err_pulse, odd_err, dir_obs;
    logic [ERR_W-1:0] err_count;

    even_updown_checker #(.WIDTH(WIDTH), .LOCK_CNT(LOCK_CNT), .ERR_W(ERR_W)) dut (
        .clk(clk), .reset(reset), .q_in(q_in), .y_in(y_in),
        .lock(lock), .err_pulse(err_pulse), .odd_err(odd_err),
        .dir_obs(dir_obs), .err_count(err_count)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic             lock;
        logic             err;
        logic             odd;
        logic             dir;
        logic [ERR_W-1:0] cnt;
    } exp_t;

    exp_t exp_q[$];
    int   checks = 0;
    int   errors = 0;

    // Reference model, written from the behavioural description
    // (0 = SYNC, 1 = ACQ, 2 = LOCKED).
    int               m_st;
    int               m_mc;
    logic [WIDTH-1:0] m_pq;
    logic             m_py;
    logic             m_lock, m_dir;
    int               m_ec;

    task automatic model_reset();
        m_st = 0; m_mc = 0; m_pq = '0; m_py = 1'b0;
        m_lock = 1'b0; m_dir = 1'b0; m_ec = 0;
    endtask

    task automatic model_step(input logic [WIDTH-1:0] q, input logic y, output exp_t e);
        logic [WIDTH-1:0] pred;
        bit match, hold, err, odd;
        err = 0; odd = 0;
        pred  = m_py ? WIDTH'(m_pq - 2) : WIDTH'(m_pq + 2);
        match = (q == pred) && (q[0] == 1'b0);
        hold  = HOLD_EN && (q == m_pq) && (q[0] == 1'b0);
        if (m_st == 0) begin
            odd  = q[0];
            m_st = 1;
        end else if (hold) begin
        end else if (match) begin
            m_dir = m_py;
            if (m_st == 1) begin
                m_mc++;
                if (m_mc == LOCK_CNT) begin m_st = 2; m_lock = 1'b1; m_mc = 0; end
            end
        end else begin
            m_mc = 0;
            odd  = q[0];
            if (m_st == 2) begin err = 1; m_lock = 1'b0; m_st = 1; end
            else err = q[0];
        end
        if (err && m_ec < (1 << ERR_W) - 1) m_ec++;
        m_pq = q; m_py = y;
        e.lock = m_lock; e.err = err; e.odd = odd; e.dir = m_dir; e.cnt = ERR_W'(m_ec);
    endtask

    // Drive one sample, push the expected outputs, then pop and compare them
    // after the capturing edge.
    task automatic send(input logic [WIDTH-1:0] q, input logic y);
        exp_t e;
        q_in = q; y_in = y;
        model_step(q, y, e);
        exp_q.push_back(e);
        @(posedge clk); #1;
        e = exp_q.pop_front();
        checks++; if (lock !== e.lock) begin errors++; $display("FAIL sb_lock q=%0d got %b exp %b", q, lock, e.lock); end
        checks++; if (err_pulse !== e.err) begin errors++; $display("FAIL sb_err_pulse q=%0d got %b exp %b", q, err_pulse, e.err); end
        checks++; if (odd_err !== e.odd) begin errors++; $display("FAIL sb_odd_err q=%0d got %b exp %b", q, odd_err, e.odd); end
        checks++; if (dir_obs !== e.dir) begin errors++; $display("FAIL sb_dir_obs q=%0d got %b exp %b", q, dir_obs, e.dir); end
        checks++; if (err_count !== e.cnt) begin errors++; $display("FAIL sb_err_count q=%0d got %0d exp %0d", q, err_count, e.cnt); end
    endtask

    task automatic do_reset();
        reset = 1'b1;
        model_reset();
        @(posedge clk); #1;
        reset = 1'b0;
        checks++;
        if ({lock, err_pulse, odd_err, dir_obs, err_count} !== '0) begin
            errors++;
            $display("FAIL reset_outputs got lock=%b err=%b odd=%b dir=%b cnt=%0d exp all 0",
                     lock, err_pulse, odd_err, dir_obs, err_count);
        end
    endtask

    task automatic test_reset();
        q_in = 4'd9; y_in = 1'b1;
        do_reset();
    endtask

    task automatic test_lock_up();
        send(4'd0, 1'b0);
        send(4'd2, 1'b0);
        checks++; if (lock !== 1'b0) begin errors++; $display("FAIL lock_early got %b exp 0", lock); end
        send(4'd4, 1'b0);
        checks++; if (lock !== 1'b1) begin errors++; $display("FAIL lock_acquire got %b exp 1", lock); end
        send(4'd6, 1'b0);
        checks++; if (err_count !== 0 || dir_obs !== 1'b0) begin
            errors++; $display("FAIL lock_up_state got cnt=%0d dir=%b exp 0/0", err_count, dir_obs); end
    endtask

    task automatic test_wrap_up();
        send(4'd8, 1'b0); send(4'd10, 1'b0); send(4'd12, 1'b0); send(4'd14, 1'b0);
        send(4'd0, 1'b0);
        checks++; if (lock !== 1'b1 || err_pulse !== 1'b0) begin
            errors++; $display("FAIL wrap_up got lock=%b err=%b exp 1/0", lock, err_pulse); end
        send(4'd2, 1'b0);
    endtask

    task automatic test_wrap_down();
        send(4'd4, 1'b0);
        send(4'd6, 1'b1);
        send(4'd4, 1'b1);
        checks++; if (dir_obs !== 1'b1) begin errors++; $display("FAIL dir_down got %b exp 1", dir_obs); end
        send(4'd2, 1'b1); send(4'd0, 1'b1); send(4'd14, 1'b1);
        checks++; if (lock !== 1'b1 || err_count !== 0) begin
            errors++; $display("FAIL wrap_down got lock=%b cnt=%0d exp 1/0", lock, err_count); end
    endtask

    task automatic test_skip();
        send(4'd12, 1'b1); send(4'd10, 1'b1); send(4'd8, 1'b1); send(4'd6, 1'b1);
        send(4'd4, 1'b0); send(4'd6, 1'b0);
        send(4'd10, 1'b0);
        checks++; if (err_pulse !== 1'b1 || err_count !== 1 || lock !== 1'b0) begin
            errors++; $display("FAIL skip_err got err=%b cnt=%0d lock=%b exp 1/1/0", err_pulse, err_count, lock); end
        send(4'd12, 1'b0);
        checks++; if (err_pulse !== 1'b0) begin errors++; $display("FAIL skip_pulse_width got %b exp 0", err_pulse); end
        send(4'd14, 1'b0);
        checks++; if (lock !== 1'b1) begin errors++; $display("FAIL skip_relock got %b exp 1", lock); end
    endtask

    task automatic test_odd();
        send(4'd0, 1'b0); send(4'd2, 1'b0); send(4'd4, 1'b0); send(4'd6, 1'b0); send(4'd8, 1'b0);
        send(4'd5, 1'b0);
        checks++; if (err_pulse !== 1'b1 || odd_err !== 1'b1 || err_count !== 2 || lock !== 1'b0) begin
            errors++; $display("FAIL odd_sample got err=%b odd=%b cnt=%0d lock=%b exp 1/1/2/0",
                               err_pulse, odd_err, err_count, lock); end
        send(4'd8, 1'b0); send(4'd10, 1'b0); send(4'd12, 1'b0);
        checks++; if (lock !== 1'b1) begin errors++; $display("FAIL odd_relock got %b exp 1", lock); end
    endtask

    task automatic test_hold();
        send(4'd14, 1'b0); send(4'd0, 1'b0); send(4'd2, 1'b0); send(4'd4, 1'b0);
        send(4'd4, 1'b0);
        checks++; if (err_pulse !== !HOLD_EN) begin
            errors++; $display("FAIL hold_repeat got %b exp %b", err_pulse, !HOLD_EN); end
        send(4'd6, 1'b0);
        checks++; if (err_pulse !== 1'b0) begin errors++; $display("FAIL hold_after got %b exp 0", err_pulse); end
    endtask

    task automatic test_reset_mid();
        send(4'd8, 1'b0); send(4'd10, 1'b0);
        q_in = 4'd12; y_in = 1'b0;
        do_reset();
        send(4'd0, 1'b0); send(4'd2, 1'b0);
        checks++; if (lock !== 1'b0) begin errors++; $display("FAIL reset_relock_early got %b exp 0", lock); end
        send(4'd4, 1'b0);
        checks++; if (lock !== 1'b1) begin errors++; $display("FAIL reset_relock got %b exp 1", lock); end
    endtask

    task automatic test_saturation();
        do_reset();
        send(4'd1, 1'b0);
        for (int i = 0; i < 260; i++) send(4'((2 * i + 3) % 16), 1'b0);
        checks++; if (err_count !== 8'd255) begin errors++; $display("FAIL saturation got %0d exp 255", err_count); end
    endtask

    task automatic test_back_to_back();
        logic [WIDTH-1:0] cur;
        logic y;
        do_reset();
        cur = 4'd6; y = 1'b0;
        for (int i = 0; i < 300; i++) begin
            if ($urandom_range(7) == 0) cur = 4'($urandom_range(15));
            else if ($urandom_range(15) == 0) cur = cur;
            else cur = y ? WIDTH'(cur - 2) : WIDTH'(cur + 2);
            if ($urandom_range(5) == 0) y = ~y;
            send(cur, y);
        end
    endtask

    initial begin
        reset = 1'b1; q_in = '0; y_in = 1'b0;
        model_reset();
        test_reset();
        test_lock_up();
        test_wrap_up();
        test_wrap_down();
        test_skip();
        test_odd();
        test_hold();
        test_reset_mid();
        test_saturation();
        test_back_to_back();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
